oled_spi_streamer: RTL and testbench
====================================

Name: oled_spi_streamer

Overview:
- Display-side end of the pixel interface. The upstream `oled_control` mux drives `oled_data` combinationally from `pixel_index`.
- This block generates `pixel_index` and samples the returned RGB565 word. It serialises the word over 4-wire SPI to the 96x64 SSD1331 OLED panel.
- It also performs panel reset/power-on and streams frames continuously.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (sclk period = 2*CLK_DIV); legal range >= 1.
- RESET_CYCLES, 1000, clk cycles `oled_res_n` is held low after reset.
- FRAME_GAP, 100, idle clk cycles with `oled_cs_n` high between frames; legal range >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- oled_data  input  16  RGB565 pixel for current `pixel_index` (combinational upstream)
- pixel_index  output  13  pixel address, y*96+x, range 0..6143
- frame_begin  output  1  one-cycle pulse at start of each frame header
- sample_pixel  output  1  one-cycle pulse on the cycle `oled_data` is captured
- sending_pixels  output  1  high while in PIXELS state
- oled_cs_n  output  1  SPI chip select, active low
- oled_sclk  output  1  SPI clock, idle low (mode 0)
- oled_mosi  output  1  SPI data, MSB first
- oled_dc  output  1  0 = command byte, 1 = pixel data byte
- oled_res_n  output  1  panel reset, active low

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values: `oled_cs_n`=1, `oled_sclk`=0, `oled_mosi`=0, `oled_dc`=0, `oled_res_n`=0, `pixel_index`=0, `frame_begin`=0, `sample_pixel`=0, `sending_pixels`=0, state=RST_HOLD.
- Reset asserted in any state aborts immediately, with no completion of the byte in flight, and returns to reset values.
- Byte shifter:
  - `oled_cs_n`=0 for the whole transfer group.
  - Per bit: `oled_mosi` is driven with `oled_sclk` low for CLK_DIV cycles, then `oled_sclk` high for CLK_DIV cycles. The panel samples on the rising edge.
  - 8 bits per byte, MSB first, giving 16*CLK_DIV clk cycles per byte.
  - Consecutive bytes within a group are back-to-back with no gap.
  - `oled_dc` is stable for the full byte.
- States:
  - RST_HOLD: `oled_res_n`=0 for RESET_CYCLES cycles, then `oled_res_n`=1 (held until next reset) and go to INIT.
  - INIT: send command 0xAF (display on), `dc`=0. Sent once per reset only. Then go to FRAME_CMD.
  - FRAME_CMD: `frame_begin`=1 on the entry cycle only. Send 0x15,0x00,0x5F,0x75,0x00,0x3F (`dc`=0) back-to-back. `pixel_index`=0 throughout. Then go to PIXELS.
  - PIXELS: `sending_pixels`=1, `dc`=1. For each pixel k=0..6143, send `oled_data[15:8]` then `oled_data[7:0]` (32*CLK_DIV cycles per pixel). After pixel 6143 go to GAP.
  - GAP: `oled_cs_n`=1, `oled_sclk`=0, `dc`=0 for FRAME_GAP cycles, then go to FRAME_CMD.
- Prefetch:
  - Pixel k's word is captured into the shift register on the final clk cycle of the preceding byte. For k=0 that is the last FRAME_CMD byte; otherwise it is pixel k-1's low byte. `sample_pixel`=1 on exactly that cycle.
  - On the cycle after capture, `pixel_index` advances to k+1. After capturing pixel 6143 it wraps to 0.
  - `oled_data` must therefore be valid for `pixel_index` at least one cycle before capture. Upstream logic is combinational, so this is always met.
- Counters:
  - `pixel_index` is a 13-bit binary counter, compare-and-wrap at 6143. It never reaches 6144.
  - Bit counter 3 bits; divider counter ceil(log2(CLK_DIV)) bits; byte counter in FRAME_CMD counts 0..5.
- Frame period (frame_begin to frame_begin) = (6 + 2*6144)*16*CLK_DIV + FRAME_GAP.
  - Defaults: 384 + 786432 + 100 = 786916 cycles.
- `sample_pixel` count per frame is exactly 6144. `frame_begin` and `sample_pixel` are never high on the same cycle.

Test Plan:
- Reset, defaults: hold `reset` 5 cycles then release -> all outputs at reset values; `oled_res_n` low for exactly 1000 cycles then high; `oled_cs_n` stays 1 until INIT.
- Init byte: decode `oled_mosi` on `oled_sclk` rising edges -> 8 edges, value 0xAF, `oled_dc`=0; byte spans 64 clk.
- Frame header: -> `frame_begin` single-cycle pulse; next 6 decoded bytes 0x15,0x00,0x5F,0x75,0x00,0x3F with `dc`=0; `pixel_index`=0 throughout.
- Pixel stream: model `oled_data` = {3'b000, pixel_index} -> decoded 16-bit words equal 0,1,...,6143 in order; `dc`=1; 6144 `sample_pixel` pulses; `pixel_index`=0 after the last capture.
- Steady state: run two frames -> `frame_begin` spacing exactly 786916 cycles; second frame has no 0xAF; `oled_cs_n`=1 for exactly 100 cycles between frames.
- Reset mid-pixel (at pixel 300, mid low byte): -> next cycle all outputs at reset values; `oled_res_n` low again for 1000 cycles; 0xAF re-sent; new frame starts at pixel 0.

Source files
------------

// File: rtl/oled_spi_streamer.sv
// oled_spi_streamer: display-side end of the pixel interface. Performs the SSD1331
// panel reset/power-on, then streams frames forever over 4-wire SPI (mode 0, MSB first).
// Each frame is a 6-byte window command header followed by every pixel as two
// RGB565 bytes. Pixel words are fetched from a combinational upstream via pixel_index.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   oled_data      RGB565 pixel for the current pixel_index
//   pixel_index    pixel address y*96+x, 0..NUM_PIXELS-1
//   frame_begin    one-cycle pulse on the first cycle of each frame header
//   sample_pixel   one-cycle pulse on the cycle oled_data is captured
//   sending_pixels high while pixel bytes are being streamed
//   oled_cs_n      SPI chip select, active low
//   oled_sclk      SPI clock, idle low
//   oled_mosi      SPI data
//   oled_dc        0 = command byte, 1 = pixel data byte
//   oled_res_n     panel reset, active low
module oled_spi_streamer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESET_CYCLES = 1000,
  parameter int unsigned FRAME_GAP    = 100,
  // Pixels per frame; 96x64 for the panel. Smaller values only shorten simulation.
  parameter int unsigned NUM_PIXELS   = 6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] oled_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sample_pixel,
  output logic        sending_pixels,
  output logic        oled_cs_n,
  output logic        oled_sclk,
  output logic        oled_mosi,
  output logic        oled_dc,
  output logic        oled_res_n
);

  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WaitMax = (RESET_CYCLES > FRAME_GAP) ? RESET_CYCLES : FRAME_GAP;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
  localparam logic [WaitW-1:0] RstLast = WaitW'(RESET_CYCLES - 1);
  localparam logic [WaitW-1:0] GapLast = WaitW'(FRAME_GAP - 1);
  localparam logic [12:0]      PixLast = 13'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    StRstHold,
    StInit,
    StFrameCmd,
    StPixels,
    StGap
  } state_e;

  state_e           state_q;
  logic [DivW-1:0]  div_q;
  logic [2:0]       bit_q;
  logic [2:0]       byte_q;
  logic             half_q;   // 0 = high byte of pixel in flight, 1 = low byte
  logic [7:0]       shift_q;
  logic [7:0]       pix_lo_q;
  logic [WaitW-1:0] wait_q;

  logic        shifting;
  logic        byte_end;
  logic        capture;
  logic [12:0] pix_next;
  logic [7:0]  hdr_next;

  assign shifting = (state_q == StInit) || (state_q == StFrameCmd) || (state_q == StPixels);

  // Last clk cycle of a byte: final bit, sclk high phase, divider expiring.
  assign byte_end = shifting && oled_sclk && (div_q == DivLast) && (bit_q == 3'd7);

  // Capture happens at the end of the last header byte (pixel 0) or at the end of a
  // low byte when more pixels remain. pixel_index has already advanced past the pixel
  // in flight, so reading 0 here means the last pixel of the frame was just sent.
  assign capture = byte_end &&
                   (((state_q == StFrameCmd) && (byte_q == 3'd5)) ||
                    ((state_q == StPixels) && half_q && (pixel_index != 13'd0)));

  // Decoded from registered state so the pulse lands exactly on the capture cycle.
  assign sample_pixel = capture;
  assign oled_mosi    = shift_q[7];
  assign pix_next     = (pixel_index == PixLast) ? 13'd0 : pixel_index + 13'd1;

  // Header byte following the one indexed by byte_q (byte 0 is 0x15).
  always_comb begin
    hdr_next = 8'h00;
    case (byte_q)
      3'd0:    hdr_next = 8'h00;
      3'd1:    hdr_next = 8'h5F;
      3'd2:    hdr_next = 8'h75;
      3'd3:    hdr_next = 8'h00;
      3'd4:    hdr_next = 8'h3F;
      default: hdr_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRstHold;
      div_q          <= '0;
      bit_q          <= 3'd0;
      byte_q         <= 3'd0;
      half_q         <= 1'b0;
      shift_q        <= 8'h00;
      pix_lo_q       <= 8'h00;
      wait_q         <= '0;
      pixel_index    <= 13'd0;
      frame_begin    <= 1'b0;
      sending_pixels <= 1'b0;
      oled_cs_n      <= 1'b1;
      oled_sclk      <= 1'b0;
      oled_dc        <= 1'b0;
      oled_res_n     <= 1'b0;
    end else begin
      frame_begin <= 1'b0;

      // Bit engine; at a byte end bit_q wraps 7->0 and the load below replaces shift_q.
      if (shifting) begin
        if (div_q == DivLast) begin
          div_q     <= '0;
          oled_sclk <= ~oled_sclk;
          if (oled_sclk) begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= {shift_q[6:0], 1'b0};
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
      end

      case (state_q)
        StRstHold: begin
          if (wait_q == RstLast) begin
            oled_res_n <= 1'b1;
            oled_cs_n  <= 1'b0;
            shift_q    <= 8'hAF;
            state_q    <= StInit;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StInit: begin
          if (byte_end) begin
            state_q     <= StFrameCmd;
            frame_begin <= 1'b1;
            byte_q      <= 3'd0;
            shift_q     <= 8'h15;
          end
        end
        StFrameCmd: begin
          if (byte_end) begin
            if (byte_q == 3'd5) begin
              state_q        <= StPixels;
              oled_dc        <= 1'b1;
              sending_pixels <= 1'b1;
              half_q         <= 1'b0;
              shift_q        <= oled_data[15:8];
              pix_lo_q       <= oled_data[7:0];
              pixel_index    <= pix_next;
            end else begin
              byte_q  <= byte_q + 3'd1;
              shift_q <= hdr_next;
            end
          end
        end
        StPixels: begin
          if (byte_end) begin
            if (!half_q) begin
              half_q  <= 1'b1;
              shift_q <= pix_lo_q;
            end else if (pixel_index == 13'd0) begin
              state_q        <= StGap;
              oled_cs_n      <= 1'b1;
              oled_dc        <= 1'b0;
              sending_pixels <= 1'b0;
              shift_q        <= 8'h00;
              wait_q         <= '0;
            end else begin
              half_q      <= 1'b0;
              shift_q     <= oled_data[15:8];
              pix_lo_q    <= oled_data[7:0];
              pixel_index <= pix_next;
            end
          end
        end
        StGap: begin
          if (wait_q == GapLast) begin
            state_q     <= StFrameCmd;
            frame_begin <= 1'b1;
            oled_cs_n   <= 1'b0;
            byte_q      <= 3'd0;
            shift_q     <= 8'h15;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StRstHold;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Directed bench for oled_spi_streamer with shortened parameters. A negedge monitor
// decodes SPI bytes on sclk rising edges and records pulses; the main sequence then
// compares them against hand-computed values.
module tb_oled_spi_streamer;

  localparam int unsigned CD     = 2;
  localparam int unsigned RC     = 20;
  localparam int unsigned FG     = 5;
  localparam int unsigned NP     = 8;
  localparam int unsigned BYTE   = 16 * CD;                       // 32 clk per byte
  localparam int unsigned PERIOD = (6 + 2 * NP) * BYTE + FG;      // 709

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] oled_data;
  logic [12:0] pixel_index;
  logic        frame_begin, sample_pixel, sending_pixels;
  logic        oled_cs_n, oled_sclk, oled_mosi, oled_dc, oled_res_n;

  assign oled_data = {3'b000, pixel_index};

  always #5 clk = ~clk;

  oled_spi_streamer #(
    .CLK_DIV     (CD),
    .RESET_CYCLES(RC),
    .FRAME_GAP   (FG),
    .NUM_PIXELS  (NP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .oled_data     (oled_data),
    .pixel_index   (pixel_index),
    .frame_begin   (frame_begin),
    .sample_pixel  (sample_pixel),
    .sending_pixels(sending_pixels),
    .oled_cs_n     (oled_cs_n),
    .oled_sclk     (oled_sclk),
    .oled_mosi     (oled_mosi),
    .oled_dc       (oled_dc),
    .oled_res_n    (oled_res_n)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int         cyc = 0;
  logic       prev_sclk = 1'b0;
  int         nbits = 0;
  logic [7:0] acc;
  logic       dc_first;
  int         dc_bad = 0;
  int         first_edge = 0;
  logic [7:0] bq[$];
  logic       bdc[$];
  int         bstart[$];
  int         fbq[$];
  int         sfb[$];
  int         pifb[$];
  int         nsamp = 0;
  int         overlap = 0;
  int         res_low = 0;
  int         cs_in_hold = 0;
  int         run = 0;
  int         runs[$];
  int         hdr_bad = 0;
  logic       in_hdr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      nbits     = 0;
      prev_sclk = 1'b0;
      run       = 0;
      in_hdr    = 1'b0;
    end else begin
      if (oled_sclk && !prev_sclk && !oled_cs_n) begin
        if (nbits == 0) begin
          dc_first   = oled_dc;
          first_edge = cyc;
        end else if (oled_dc !== dc_first) begin
          dc_bad++;
        end
        acc = {acc[6:0], oled_mosi};
        nbits++;
        if (nbits == 8) begin
          bq.push_back(acc);
          bdc.push_back(dc_first);
          bstart.push_back(first_edge);
          nbits = 0;
        end
      end
      prev_sclk = oled_sclk;
      if (frame_begin) begin
        fbq.push_back(cyc);
        sfb.push_back(nsamp);
        pifb.push_back(int'(pixel_index));
        in_hdr = 1'b1;
      end
      if (sample_pixel) begin
        nsamp++;
        in_hdr = 1'b0;
      end
      if (in_hdr && pixel_index != 13'd0) hdr_bad++;
      if (frame_begin && sample_pixel) overlap++;
      if (!oled_res_n) res_low++;
      if (!oled_res_n && !oled_cs_n) cs_in_hold++;
      if (oled_res_n && oled_cs_n) run++;
      else if (oled_res_n && !oled_cs_n && run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  function automatic logic [31:0] outs_vec();
    return {11'd0, oled_cs_n, oled_sclk, oled_mosi, oled_dc, oled_res_n, frame_begin,
            sample_pixel, sending_pixels, pixel_index};
  endfunction

  // cs_n=1, everything else 0
  localparam logic [31:0] RstVec = 32'h0010_0000;

  logic [7:0] exp_b[24];
  logic       exp_dc[24];

  initial begin
    int k;
    exp_b[0] = 8'hAF; exp_b[1] = 8'h15; exp_b[2] = 8'h00; exp_b[3] = 8'h5F;
    exp_b[4] = 8'h75; exp_b[5] = 8'h00; exp_b[6] = 8'h3F;
    for (int p = 0; p < int'(NP); p++) begin
      exp_b[7 + 2 * p] = 8'h00;
      exp_b[8 + 2 * p] = 8'(p);
    end
    exp_b[23] = 8'h15;
    for (int i = 0; i < 24; i++) exp_dc[i] = (i >= 7 && i < 23);

    // Reset held 5 cycles
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", outs_vec(), RstVec);
    reset = 1'b0;

    k = 0;
    while (oled_res_n !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    check("res_n_rise", {31'd0, oled_res_n}, 32'd1);
    check("res_low_cycles", res_low, RC);
    check("cs_high_in_hold", cs_in_hold, 0);

    k = 0;
    while (bq.size() < 24 && k < 3000) begin @(posedge clk); #1; k++; end
    check("byte_count", bq.size() >= 24, 1);
    if (bq.size() >= 24) begin
      for (int i = 0; i < 24; i++) begin
        check($sformatf("byte%0d", i), bq[i], exp_b[i]);
        check($sformatf("dc%0d", i), bdc[i], exp_dc[i]);
      end
      check("init_byte_span", bstart[1] - bstart[0], BYTE);
      check("hdr_back_to_back", bstart[6] - bstart[1], 5 * BYTE);
    end
    check("dc_stable", dc_bad, 0);
    check("fb_count", fbq.size() >= 2, 1);
    if (fbq.size() >= 2) begin
      check("frame_period", fbq[1] - fbq[0], PERIOD);
      check("samples_per_frame", sfb[1] - sfb[0], NP);
      check("first_fb_samples", sfb[0], 0);
      check("pi_at_fb0", pifb[0], 0);
      check("pi_after_wrap", pifb[1], 0);
    end
    check("hdr_pixel_index", hdr_bad, 0);
    check("fb_sp_overlap", overlap, 0);
    check("gap_runs", runs.size() >= 1, 1);
    if (runs.size() >= 1) check("gap_len", runs[0], FG);

    // Reset in the middle of pixel 5's low byte
    k = 0;
    while (pixel_index !== 13'd6 && k < 2000) begin @(posedge clk); #1; k++; end
    check("reach_pixel5", {19'd0, pixel_index}, 32'd6);
    repeat (BYTE + BYTE / 2) @(posedge clk);
    #1;
    check("mid_low_byte_busy", {31'd0, oled_cs_n}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", outs_vec(), RstVec);
    repeat (2) @(posedge clk);
    #1;
    bq.delete();
    bdc.delete();
    bstart.delete();
    res_low = 0;
    reset = 1'b0;

    k = 0;
    while (bq.size() < 9 && k < 2000) begin @(posedge clk); #1; k++; end
    check("re_byte_count", bq.size() >= 9, 1);
    check("re_res_low", res_low, RC);
    if (bq.size() >= 9) begin
      check("re_init_byte", bq[0], 8'hAF);
      check("re_hdr0", bq[1], 8'h15);
      check("re_hdr5", bq[6], 8'h3F);
      check("re_pix0_hi", bq[7], 8'h00);
      check("re_pix0_lo", bq[8], 8'h00);
      check("re_pix0_dc", bdc[8], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
